// File: rtl/ddr3_addr_cmd_dly_seq_if.sv
// DDR3 addr/cmd delay sequencer bus.
// Calibration request side plus lane-controller delay-line side.
interface ddr3_addr_cmd_dly_seq_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_LOAD;
  logic       REQ_DIR;
  logic [6:0] REQ_STEPS;
  logic       DONE;
  logic       ERR;
  logic [7:0] TAP_COUNT;
  logic       DELAY_LINE_SEL;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_MOVE;
  logic       HS_IO_CLK_PAUSE;
  logic       TX_DELAY_LINE_OUT_OF_RANGE;

  modport master (
    output REQ_VALID, REQ_LOAD, REQ_DIR, REQ_STEPS,
    output TX_DELAY_LINE_OUT_OF_RANGE,
    input  REQ_READY, DONE, ERR, TAP_COUNT,
    input  DELAY_LINE_SEL, DELAY_LINE_LOAD,
    input  DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
    input  HS_IO_CLK_PAUSE
  );

  modport slave (
    input  REQ_VALID, REQ_LOAD, REQ_DIR, REQ_STEPS,
    input  TX_DELAY_LINE_OUT_OF_RANGE,
    output REQ_READY, DONE, ERR, TAP_COUNT,
    output DELAY_LINE_SEL, DELAY_LINE_LOAD,
    output DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
    output HS_IO_CLK_PAUSE
  );
endinterface

// File: rtl/ddr3_addr_cmd_dly_seq.sv
// DDR3 addr/cmd delay-line sequencer.
// Wraps tap load/move pulses in an HS_IO_CLK pause window.
module ddr3_addr_cmd_dly_seq #(
  parameter int PAUSE_SETUP = 2,
  parameter int MOVE_GAP    = 3,
  parameter int PAUSE_HOLD  = 2,
  parameter int LOAD_TAP    = 1,
  parameter int MAX_TAP     = 127
) (
  input logic FAB_CLK,
  input logic RESET,
  ddr3_addr_cmd_dly_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PAUSE, ACT, GAP, UNPAUSE, DONE_ST
  } state_t;

  localparam logic [3:0] SETUP_C = 4'(PAUSE_SETUP - 1);
  localparam logic [3:0] GAP_C   = 4'(MOVE_GAP - 1);
  localparam logic [3:0] HOLD_C  = 4'(PAUSE_HOLD - 1);
  localparam logic [7:0] LOAD_C  = 8'(LOAD_TAP);
  localparam logic [7:0] MAX_C   = 8'(MAX_TAP);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [6:0] steps, steps_nx;
  logic       ld, ld_nx;
  logic       dir, dir_nx;
  logic [7:0] tap, tap_nx;
  logic       err, err_nx;
  logic       load_q, load_nx;
  logic       move_q, move_nx;
  logic       pause_q, dir_q, ready_q, done_q;
  logic       try_act, blocked;

  assign blocked = dir ? (tap >= MAX_C) : (tap == 8'd0);

  // next-state, counters, tap tracking and pulse generation
  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    steps_nx = steps;
    ld_nx    = ld;
    dir_nx   = dir;
    tap_nx   = tap;
    err_nx   = err;
    load_nx  = 1'b0;
    move_nx  = 1'b0;
    try_act  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.REQ_VALID) begin
          ld_nx    = bus.REQ_LOAD;
          dir_nx   = bus.REQ_DIR & ~bus.REQ_LOAD;
          steps_nx = bus.REQ_LOAD ? 7'd0 : bus.REQ_STEPS;
          err_nx   = 1'b0;
          if (!bus.REQ_LOAD && bus.REQ_STEPS == 7'd0) begin
            state_nx = DONE_ST;
          end else begin
            state_nx = PAUSE;
            cnt_nx   = SETUP_C;
          end
        end
      end
      PAUSE: begin
        if (cnt == 4'd0) try_act = 1'b1;
      end
      ACT: begin
        state_nx = GAP;
        cnt_nx   = GAP_C;
      end
      GAP: begin
        if (cnt == 4'd0) begin
          if (bus.TX_DELAY_LINE_OUT_OF_RANGE) begin
            err_nx   = 1'b1;
            state_nx = UNPAUSE;
            cnt_nx   = HOLD_C;
          end else if (steps != 7'd0) begin
            try_act = 1'b1;
          end else begin
            state_nx = UNPAUSE;
            cnt_nx   = HOLD_C;
          end
        end
      end
      UNPAUSE: begin
        if (cnt == 4'd0) state_nx = DONE_ST;
      end
      DONE_ST: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (try_act) begin
      if (ld) begin
        state_nx = ACT;
        load_nx  = 1'b1;
        tap_nx   = LOAD_C;
      end else if (blocked) begin
        err_nx   = 1'b1;
        state_nx = UNPAUSE;
        cnt_nx   = HOLD_C;
      end else begin
        state_nx = ACT;
        move_nx  = 1'b1;
        steps_nx = steps - 7'd1;
        tap_nx   = dir ? tap + 8'd1 : tap - 8'd1;
      end
    end
  end

  // state, tracking and registered outputs
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      steps   <= 7'd0;
      ld      <= 1'b0;
      dir     <= 1'b0;
      tap     <= LOAD_C;
      err     <= 1'b0;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      pause_q <= 1'b0;
      dir_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      steps   <= steps_nx;
      ld      <= ld_nx;
      dir     <= dir_nx;
      tap     <= tap_nx;
      err     <= err_nx;
      load_q  <= load_nx;
      move_q  <= move_nx;
      pause_q <= (state_nx == PAUSE) || (state_nx == ACT)
              || (state_nx == GAP);
      dir_q   <= ((state_nx == PAUSE) || (state_nx == ACT)
              || (state_nx == GAP) || (state_nx == UNPAUSE))
              ? dir_nx : 1'b0;
      ready_q <= (state_nx == IDLE);
      done_q  <= (state_nx == DONE_ST);
    end
  end

  assign bus.REQ_READY            = ready_q;
  assign bus.DONE                 = done_q;
  assign bus.ERR                  = err;
  assign bus.TAP_COUNT            = tap;
  assign bus.DELAY_LINE_SEL       = pause_q;
  assign bus.HS_IO_CLK_PAUSE      = pause_q;
  assign bus.DELAY_LINE_LOAD      = load_q;
  assign bus.DELAY_LINE_MOVE      = move_q;
  assign bus.DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_ddr3_addr_cmd_dly_seq.sv
// Bench for ddr3_addr_cmd_dly_seq.
// Cycle-timeline reference model plus directed and random requests.
module tb_ddr3_addr_cmd_dly_seq;
  localparam int PS = 2;
  localparam int G  = 3;
  localparam int H  = 2;
  localparam int LT = 1;
  localparam int MX = 127;

  logic FAB_CLK = 1'b0;
  logic RESET   = 1'b1;

  ddr3_addr_cmd_dly_seq_if bus();

  ddr3_addr_cmd_dly_seq #(
    .PAUSE_SETUP(PS), .MOVE_GAP(G), .PAUSE_HOLD(H),
    .LOAD_TAP(LT), .MAX_TAP(MX)
  ) dut (
    .FAB_CLK(FAB_CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] tap;
    logic       sel;
    logic       load;
    logic       dir;
    logic       move;
    logic       pause;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc   = -2;
  int m_tap = LT;
  bit m_err = 1'b0;
  bit r_ld, r_dir, zero, err_f;
  int r_oor, p, W, D, tap_f;
  int pulses[$];
  int loads[$];
  int rise, fall, done_c;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, got, want, $time);
    end
  endtask

  // Expected outputs c cycles after accept (c<1: idle before request).
  function automatic exp_t model(int c);
    exp_t e;
    int sp, np;
    bit win, hold, pul;
    e = '0;
    e.ready = 1'b1;
    e.tap = 8'(m_tap);
    e.err = m_err;
    if (c < 1) return e;
    if (c > D) begin
      e.tap = 8'(tap_f);
      e.err = err_f;
      return e;
    end
    e.ready = 1'b0;
    e.err = 1'b0;
    e.done = (c == D);
    if (zero) return e;
    sp = 1 + G;
    win = (c <= W);
    hold = (c > W) && (c <= W + H);
    np = (c < PS + 1) ? 0 : (c - PS - 1) / sp + 1;
    if (np > p) np = p;
    pul = (c >= PS + 1) && ((c - PS - 1) % sp == 0)
       && ((c - PS - 1) / sp < p);
    e.pause = win;
    e.sel = win;
    e.dir = (win || hold) ? r_dir : 1'b0;
    e.load = r_ld && pul;
    e.move = !r_ld && pul;
    if (r_ld) e.tap = (np > 0) ? 8'(LT) : 8'(m_tap);
    else e.tap = 8'(r_dir ? m_tap + np : m_tap - np);
    e.err = err_f && (c > W);
    return e;
  endfunction

  task automatic plan(input bit ld, input bit dir,
                      input int steps, input int oork);
    int avail, pn;
    r_ld = ld;
    r_dir = dir & ~ld;
    zero = !ld && steps == 0;
    r_oor = -1;
    if (zero) begin
      p = 0; W = 0; D = 1; tap_f = m_tap; err_f = 1'b0;
      return;
    end
    if (ld) begin
      pn = 1;
      err_f = 1'b0;
    end else begin
      avail = dir ? MX - m_tap : m_tap;
      pn = (steps < avail) ? steps : avail;
      err_f = steps > avail;
    end
    if (oork >= 0 && oork < pn) begin
      p = oork + 1;
      err_f = 1'b1;
      r_oor = oork;
    end else begin
      p = pn;
    end
    W = PS + p * (1 + G);
    D = W + H + 1;
    tap_f = ld ? LT : (dir ? m_tap + p : m_tap - p);
  endtask

  task automatic run(input bit ld, input bit dir, input int steps,
                     input int oork, input int rst_at);
    plan(ld, dir, steps, oork);
    pulses.delete();
    loads.delete();
    rise = -1; fall = -1; done_c = -1;
    @(negedge FAB_CLK);
    bus.REQ_VALID = 1'b1;
    bus.REQ_LOAD = ld;
    bus.REQ_DIR = dir;
    bus.REQ_STEPS = 7'(steps);
    for (int c = 1; c <= D + 1; c++) begin
      @(negedge FAB_CLK);
      cyc = c;
      if (c <= D) begin
        bus.REQ_VALID = 1'($urandom_range(0, 1));
        bus.REQ_LOAD = 1'($urandom_range(0, 1));
        bus.REQ_DIR = 1'($urandom_range(0, 1));
        bus.REQ_STEPS = 7'($urandom_range(0, 127));
      end else begin
        bus.REQ_VALID = 1'b0;
      end
      bus.TX_DELAY_LINE_OUT_OF_RANGE = (r_oor >= 0)
        && (c >= PS + 2 + r_oor * (1 + G))
        && (c <= PS + (r_oor + 1) * (1 + G));
      #3;
      if (bus.HS_IO_CLK_PAUSE && rise < 0) rise = c;
      if (!bus.HS_IO_CLK_PAUSE && rise >= 0 && fall < 0) fall = c;
      if (bus.DELAY_LINE_MOVE) pulses.push_back(c);
      if (bus.DELAY_LINE_LOAD) loads.push_back(c);
      if (bus.DONE && done_c < 0) done_c = c;
      if (c == rst_at) begin
        RESET = 1'b1;
        @(negedge FAB_CLK);
        cyc = -1;
        m_tap = LT;
        m_err = 1'b0;
        RESET = 1'b0;
        bus.REQ_VALID = 1'b0;
        bus.TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        #3;
        chk("rst_mid_pause", int'(bus.HS_IO_CLK_PAUSE), 0);
        chk("rst_mid_move", int'(bus.DELAY_LINE_MOVE), 0);
        chk("rst_mid_tap", int'(bus.TAP_COUNT), 1);
        chk("rst_mid_ready", int'(bus.REQ_READY), 1);
        return;
      end
    end
    bus.TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
    m_tap = tap_f;
    m_err = err_f;
    cyc = -1;
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // per-cycle comparison of every output against the model
  always @(negedge FAB_CLK) begin
    exp_t e;
    #2;
    if (cyc != -2) begin
      e = model(cyc);
      chk("req_ready", int'(bus.REQ_READY), int'(e.ready));
      chk("done", int'(bus.DONE), int'(e.done));
      chk("err", int'(bus.ERR), int'(e.err));
      chk("tap_count", int'(bus.TAP_COUNT), int'(e.tap));
      chk("sel", int'(bus.DELAY_LINE_SEL), int'(e.sel));
      chk("load", int'(bus.DELAY_LINE_LOAD), int'(e.load));
      chk("direction", int'(bus.DELAY_LINE_DIRECTION), int'(e.dir));
      chk("move", int'(bus.DELAY_LINE_MOVE), int'(e.move));
      chk("pause", int'(bus.HS_IO_CLK_PAUSE), int'(e.pause));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.REQ_VALID = 1'b0;
    bus.REQ_LOAD = 1'b0;
    bus.REQ_DIR = 1'b0;
    bus.REQ_STEPS = 7'd0;
    bus.TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
    RESET = 1'b1;
    repeat (3) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    RESET = 1'b0;
    cyc = -1;
    repeat (10) @(negedge FAB_CLK);
    #3;
    chk("idle_tap", int'(bus.TAP_COUNT), 1);
    chk("idle_ready", int'(bus.REQ_READY), 1);

    run(1'b0, 1'b1, 3, -1, 0);
    chk("up3_rise", rise, 1);
    chk("up3_fall", fall, 15);
    chk("up3_npulse", pulses.size(), 3);
    chk("up3_p0", qat(pulses, 0), 3);
    chk("up3_p1", qat(pulses, 1), 7);
    chk("up3_p2", qat(pulses, 2), 11);
    chk("up3_done", done_c, 17);
    chk("up3_tap", int'(bus.TAP_COUNT), 4);
    chk("up3_err", int'(bus.ERR), 0);

    run(1'b1, 1'b0, 0, -1, 0);
    chk("ld_nload", loads.size(), 1);
    chk("ld_at", qat(loads, 0), 3);
    chk("ld_nmove", pulses.size(), 0);
    chk("ld_done", done_c, 9);
    chk("ld_tap", int'(bus.TAP_COUNT), 1);

    run(1'b0, 1'b0, 5, -1, 0);
    chk("dn5_npulse", pulses.size(), 1);
    chk("dn5_tap", int'(bus.TAP_COUNT), 0);
    chk("dn5_err", int'(bus.ERR), 1);
    chk("dn5_fall", fall, 7);
    chk("dn5_done", done_c, 9);

    run(1'b1, 1'b1, 9, -1, 0);
    run(1'b0, 1'b1, 4, 0, 0);
    chk("oor_npulse", pulses.size(), 1);
    chk("oor_err", int'(bus.ERR), 1);
    chk("oor_tap", int'(bus.TAP_COUNT), 2);
    chk("oor_done", done_c, 9);

    run(1'b0, 1'b1, 4, -1, 8);

    run(1'b0, 1'b1, 0, -1, 0);
    chk("z_done", done_c, 1);
    chk("z_rise", rise, -1);

    run(1'b0, 1'b1, 127, -1, 0);
    chk("top_tap", int'(bus.TAP_COUNT), 127);
    chk("top_err", int'(bus.ERR), 1);
    chk("top_npulse", pulses.size(), 126);

    run(1'b0, 1'b1, 1, -1, 0);
    chk("top_blk_npulse", pulses.size(), 0);
    chk("top_blk_done", done_c, 5);

    repeat (40) begin
      run(($urandom % 5) == 0, 1'($urandom_range(0, 1)),
          (($urandom % 4) == 0) ? $urandom_range(0, 40)
                                : $urandom_range(0, 6),
          (($urandom % 3) == 0) ? $urandom_range(0, 3) : -1,
          0);
    end

    repeat (3) @(negedge FAB_CLK);
    #3;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ddr3_addr_cmd_dly_seq.md
Name: ddr3_addr_cmd_dly_seq

Overview:
Fabric-side sequencer directly upstream of the DDR3 address/command lane controller. It converts tap-adjust requests from calibration logic into the lane controller's delay-line control signals: DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE and HS_IO_CLK_PAUSE. Every adjustment is wrapped in an HS_IO_CLK pause window. The block tracks the resulting TX delay tap and aborts on out-of-range.

Parameters:
PAUSE_SETUP, 2, cycles HS_IO_CLK_PAUSE is held high before the first LOAD/MOVE pulse (1..15)
MOVE_GAP, 3, idle cycles after each LOAD/MOVE pulse (1..15)
PAUSE_HOLD, 2, cycles after HS_IO_CLK_PAUSE drops before DONE (1..15)
LOAD_TAP, 1, tap value after a LOAD; matches the lane's TX delay reset value
MAX_TAP, 127, highest legal tap

Ports:
FAB_CLK  in  1  fabric clock; every register is clocked on its rising edge
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  high only in IDLE
REQ_LOAD  in  1  1 = reload the delay line to LOAD_TAP; REQ_DIR and REQ_STEPS are ignored
REQ_DIR  in  1  1 = increment the tap, 0 = decrement
REQ_STEPS  in  7  number of MOVE pulses
DONE  out  1  one-cycle pulse when a request completes
ERR  out  1  sticky abort flag
TAP_COUNT  out  8  current tracked tap
DELAY_LINE_SEL  out  1  to lane controller
DELAY_LINE_LOAD  out  1  to lane controller
DELAY_LINE_DIRECTION  out  1  to lane controller
DELAY_LINE_MOVE  out  1  to lane controller
HS_IO_CLK_PAUSE  out  1  to lane controller
TX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller

Behaviour:
- Reset values:
  - state = IDLE; REQ_READY = 1.
  - DONE, ERR, SEL, LOAD, DIRECTION, MOVE and PAUSE = 0.
  - TAP_COUNT = LOAD_TAP.
- Reset mid-operation: the same reset values apply on the next edge. PAUSE and MOVE drop immediately; there is no unpause hold.
- All outputs are registered.
- Request accept:
  - A request is accepted on a cycle where REQ_VALID=1 and state=IDLE.
  - On accept, REQ_LOAD, REQ_DIR and REQ_STEPS are captured into internal registers and ERR is cleared.
  - If REQ_LOAD=0 and REQ_STEPS=0: the block goes to DONE_ST with no pause; DONE pulses 1 cycle after accept.
- PAUSE state:
  - HS_IO_CLK_PAUSE=1 and DELAY_LINE_SEL=1.
  - DELAY_LINE_DIRECTION = captured direction.
  - Lasts PAUSE_SETUP cycles, then ACT.
- ACT state (1 cycle):
  - LOAD request: DELAY_LINE_LOAD=1; TAP_COUNT is set to LOAD_TAP.
  - MOVE request: DELAY_LINE_MOVE=1; TAP_COUNT +1 when DIR=1, -1 when DIR=0; the remaining-step count decrements.
  - Pre-check before pulsing: if the move would pass MAX_TAP (DIR=1) or go below 0 (DIR=0), no pulse is issued, ERR is set, and the block goes to UNPAUSE.
- GAP state:
  - MOVE_GAP cycles, with LOAD and MOVE low.
  - TX_DELAY_LINE_OUT_OF_RANGE is sampled on the last GAP cycle. If high: ERR=1 and go to UNPAUSE.
  - Else, if remaining steps > 0: go to ACT.
  - Else: go to UNPAUSE.
- UNPAUSE state:
  - HS_IO_CLK_PAUSE=0 and DELAY_LINE_SEL=0.
  - DIRECTION is held for PAUSE_HOLD cycles, then DONE_ST.
- DONE_ST state: DONE=1 for 1 cycle, then IDLE.
- DIRECTION and SEL are stable during the whole pause window. The MOVE edges therefore never coincide with PAUSE or DIRECTION edges.
- MOVE pulse spacing is exactly 1+MOVE_GAP cycles.
- A MOVE request of N steps takes PAUSE_SETUP + N*(1+MOVE_GAP) + PAUSE_HOLD + 1 cycles from accept to DONE. The accept cycle itself is counted as cycle 0.
- REQ_VALID outside IDLE is ignored; no queueing.
- ERR remains set until the next accepted request or RESET.

Test Plan:
- Reset then idle -> TAP_COUNT=1, REQ_READY=1, every other output 0, for 10 cycles.
- MOVE, DIR=1, STEPS=3, default params:
  - PAUSE rises at cycle 1; MOVE pulses at cycles 3, 7, 11; PAUSE falls at cycle 15.
  - DONE at cycle 17; TAP_COUNT=4; ERR=0.
- LOAD after TAP_COUNT=4 -> one LOAD pulse at cycle 3; TAP_COUNT=1; DONE at cycle 9; no MOVE pulse.
- DIR=0, STEPS=5 from TAP_COUNT=1:
  - One MOVE pulse; TAP_COUNT=0.
  - Second ACT is blocked: ERR=1, PAUSE drops, DONE is issued.
- OUT_OF_RANGE forced high during the first GAP of STEPS=4, DIR=1 -> only 1 MOVE pulse; ERR=1; TAP_COUNT=2; DONE is issued.
- RESET asserted during the second GAP -> next cycle PAUSE=0, TAP_COUNT=1, REQ_READY=1.
- STEPS=0 -> DONE 1 cycle after accept; PAUSE never asserts.
